// File: rtl/ariane_pkg.sv
// Shared core types: BHT update payload and the update-scheduler FSM state.
package ariane_pkg;

    localparam int unsigned VLEN = 64;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } bht_sched_state_e;

endpackage

// File: rtl/bht_upd_fifo.sv
// BHT update buffer: up to NR_PUSH in-order pushes and one pop per cycle, with flush.
module bht_upd_fifo
    import ariane_pkg::*;
#(
    parameter int unsigned NR_PUSH = 2,
    parameter int unsigned DEPTH   = 4,
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
    localparam int unsigned PC_W   = $clog2(NR_PUSH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush,
    input  logic [PC_W-1:0]           push_cnt,
    input  bht_update_t [NR_PUSH-1:0] push_data,
    input  logic                      pop,
    output bht_update_t               head,
    output logic                      empty,
    output logic [CNT_W-1:0]          count
);

    bht_update_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + PTR_W'(push_cnt);
            rd_q  <= rd_q + PTR_W'(pop);
            cnt_q <= cnt_q + CNT_W'(push_cnt) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned j = 0; j < NR_PUSH; j++) begin
            if (!flush && (PC_W'(j) < push_cnt)) begin
                mem_q[wr_q + PTR_W'(j)] <= push_data[j];
            end
        end
    end

    assign head  = mem_q[rd_q];
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/bht_update_sched.sv
// Arbitrates BHT update requesters into a single table update port and sequences table clears.
// Define BHT_SCHED_CLEAR_WALK_EN for a row-by-row sweep; otherwise a single clr_all_o strobe is issued.
module bht_update_sched
    import ariane_pkg::*;
#(
    parameter int unsigned NR_REQ     = 2,
    parameter int unsigned NR_ROWS    = 512,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned ROW_W     = (NR_ROWS > 1) ? $clog2(NR_ROWS) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     debug_mode_i,
    input  bht_update_t [NR_REQ-1:0] req_i,
    output logic [NR_REQ-1:0]        req_ready_o,
    output bht_update_t              upd_o,
    output logic                     clr_valid_o,
    output logic [ROW_W-1:0]         clr_row_o,
    output logic                     clr_all_o,
    output logic                     busy_o
);

    localparam int unsigned RR_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PC_W  = $clog2(NR_REQ + 1);

    bht_sched_state_e         state_q;
    logic [RR_W-1:0]          rr_q;
    logic                     ready_all;
    logic                     accept_en;
    logic                     pop;
    logic [PC_W-1:0]          push_cnt;
    bht_update_t [NR_REQ-1:0] push_data;
    bht_update_t              fifo_head;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         fifo_cnt;
    int unsigned              n;
    int unsigned              idx;

    // Only registered occupancy gates readiness; a same-cycle pop gives no credit.
    assign ready_all   = (state_q == IDLE) && (fifo_cnt <= CNT_W'(FIFO_DEPTH - NR_REQ));
    assign req_ready_o = {NR_REQ{ready_all}};
    assign accept_en   = ready_all && !debug_mode_i && !flush_i;
    assign pop         = (state_q == IDLE) && !flush_i && !fifo_empty;
    assign upd_o       = pop ? fifo_head : '0;
    assign busy_o      = (state_q == CLEAR) || !fifo_empty;

    // Compact accepted requests starting at rr_q so they enter the FIFO in round-robin order.
    always_comb begin
        n         = 0;
        idx       = 0;
        push_data = '0;
        for (int unsigned i = 0; i < NR_REQ; i++) begin
            idx = (32'(rr_q) + i) % NR_REQ;
            if (accept_en && req_i[idx[RR_W-1:0]].valid) begin
                push_data[RR_W'(n)] = req_i[idx[RR_W-1:0]];
                n = n + 1;
            end
        end
        push_cnt = PC_W'(n);
    end

    bht_upd_fifo #(
        .NR_PUSH (NR_REQ),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush     (flush_i),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

`ifdef BHT_SCHED_CLEAR_WALK_EN
    logic [ROW_W-1:0] row_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            row_q   <= '0;
        end else begin
            if (push_cnt != '0) begin
                rr_q <= (rr_q == RR_W'(NR_REQ - 1)) ? '0 : rr_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        state_q <= CLEAR;
                        row_q   <= '0;
                    end
                end
                CLEAR: begin
                    if (flush_i) begin
                        row_q <= '0;
                    end else if (row_q == ROW_W'(NR_ROWS - 1)) begin
                        state_q <= IDLE;
                        row_q   <= '0;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clr_valid_o = (state_q == CLEAR);
    assign clr_row_o   = row_q;
    assign clr_all_o   = 1'b0;
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
        end else begin
            if (push_cnt != '0) begin
                rr_q <= (rr_q == RR_W'(NR_REQ - 1)) ? '0 : rr_q + 1'b1;
            end
            unique case (state_q)
                IDLE:    if (flush_i) state_q <= CLEAR;
                CLEAR:   if (!flush_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clr_valid_o = 1'b0;
    assign clr_row_o   = '0;
    assign clr_all_o   = (state_q == CLEAR);
`endif

endmodule

// File: tb/tb_bht_update_sched.sv
// Scoreboard bench for bht_update_sched; follows BHT_SCHED_CLEAR_WALK_EN like the design.
module tb_bht_update_sched;
    import ariane_pkg::*;

    localparam int unsigned NR    = 2;
    localparam int unsigned ROWS  = 512;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ROW_W = $clog2(ROWS);
`ifdef BHT_SCHED_CLEAR_WALK_EN
    localparam int unsigned BUSY_CYC = ROWS + 1;
`else
    localparam int unsigned BUSY_CYC = 2;
`endif

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 flush_i = 1'b0;
    logic                 debug_mode_i = 1'b0;
    bht_update_t [NR-1:0] req_i = '0;
    logic [NR-1:0]        req_ready_o;
    bht_update_t          upd_o;
    logic                 clr_valid_o;
    logic [ROW_W-1:0]     clr_row_o;
    logic                 clr_all_o;
    logic                 busy_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    bht_update_t  exp_q[$];
    logic [63:0]  out_log[$];
    logic [NR-1:0] acc_mask;
    bit           m_clear = 0;
    int unsigned  m_row = 0;
    int unsigned  m_rr = 0;
    bit           last_busy;
    bit           last_ready;

    bht_update_sched #(
        .NR_REQ     (NR),
        .NR_ROWS    (ROWS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .debug_mode_i (debug_mode_i),
        .req_i        (req_i),
        .req_ready_o  (req_ready_o),
        .upd_o        (upd_o),
        .clr_valid_o  (clr_valid_o),
        .clr_row_o    (clr_row_o),
        .clr_all_o    (clr_all_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: compare outputs at the falling edge, then advance the reference model.
    task automatic tick();
        int unsigned sz;
        bit          er;
        bit          ev;
        bit          pushed;
        int unsigned k;
        bht_update_t e;
        @(negedge clk_i);
        sz = exp_q.size();
        er = !m_clear && (sz <= DEPTH - NR);
        ev = !m_clear && !flush_i && (sz != 0);
        check("ready", 64'(req_ready_o), er ? 64'(2**NR - 1) : 64'd0);
        check("upd_valid", 64'(upd_o.valid), 64'(ev));
        if (ev) begin
            e = exp_q.pop_front();
            check("upd_pc", upd_o.pc, e.pc);
            check("upd_taken", 64'(upd_o.taken), 64'(e.taken));
            out_log.push_back(upd_o.pc);
        end else begin
            check("upd_zero", upd_o.pc | 64'(upd_o.taken), 64'd0);
        end
        check("busy", 64'(busy_o), 64'(m_clear || (sz != 0)));
`ifdef BHT_SCHED_CLEAR_WALK_EN
        check("clr_valid", 64'(clr_valid_o), 64'(m_clear));
        check("clr_row", 64'(clr_row_o), m_clear ? 64'(m_row) : 64'd0);
        check("clr_all", 64'(clr_all_o), 64'd0);
`else
        check("clr_all", 64'(clr_all_o), 64'(m_clear));
        check("clr_valid_row", 64'(clr_valid_o) | 64'(clr_row_o), 64'd0);
`endif
        last_busy  = busy_o;
        last_ready = req_ready_o[0];
        acc_mask   = '0;
        pushed     = 0;
        if (er && !flush_i) begin
            for (int unsigned i = 0; i < NR; i++) begin
                k = (m_rr + i) % NR;
                if (req_i[k].valid) begin
                    acc_mask[k] = 1'b1;
                    if (!debug_mode_i) begin
                        exp_q.push_back(req_i[k]);
                        pushed = 1;
                    end
                end
            end
        end
        if (pushed) m_rr = (m_rr + 1) % NR;
        if (flush_i) begin
            exp_q.delete();
            m_clear = 1;
            m_row   = 0;
        end else if (m_clear) begin
`ifdef BHT_SCHED_CLEAR_WALK_EN
            if (m_row == ROWS - 1) begin
                m_clear = 0;
                m_row   = 0;
            end else begin
                m_row++;
            end
`else
            m_clear = 0;
`endif
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni       = 1'b0;
        flush_i      = 1'b0;
        debug_mode_i = 1'b0;
        req_i        = '0;
        #2;
        check("rst_ready", 64'(req_ready_o), 64'(2**NR - 1));
        check("rst_upd_pc", upd_o.pc, 64'd0);
        check("rst_upd_vt", 64'({upd_o.valid, upd_o.taken}), 64'd0);
        check("rst_clr", 64'({clr_valid_o, clr_all_o, busy_o}), 64'd0);
        check("rst_row", 64'(clr_row_o), 64'd0);
        repeat (2) @(posedge clk_i);
        exp_q.delete();
        m_clear = 0;
        m_row   = 0;
        m_rr    = 0;
        #1 rst_ni = 1'b1;
    endtask

    // Cycles from the current point until busy_o is seen low, bounded.
    task automatic busy_fall(input string tag);
        int unsigned cyc;
        cyc = 0;
        for (int unsigned c = 1; c <= BUSY_CYC + 50; c++) begin
            tick();
            cyc = c;
            if (!last_busy) break;
        end
        check(tag, 64'(cyc), 64'(BUSY_CYC));
    endtask

    function automatic bht_update_t mk(input logic [63:0] pc);
        bht_update_t r;
        r.valid = 1'b1;
        r.pc    = pc;
        r.taken = pc[3];
        return r;
    endfunction

    initial begin
        logic [63:0] p0;
        logic [63:0] p1;
        int unsigned low_seen;
        int unsigned acc_cnt;

        do_reset();

        // Round-robin order and one-cycle latency from an empty FIFO.
        out_log.delete();
        req_i[0] = mk(64'h100);
        req_i[1] = mk(64'h200);
        tick();
        req_i[0] = mk(64'h300);
        req_i[1] = mk(64'h400);
        tick();
        check("lat1", 64'(out_log.size()), 64'd1);
        req_i = '0;
        tick();
        check("lat2", 64'(out_log.size()), 64'd2);
        repeat (3) tick();
        check("ord_n", 64'(out_log.size()), 64'd4);
        check("ord0", out_log[0], 64'h100);
        check("ord1", out_log[1], 64'h200);
        check("ord2", out_log[2], 64'h400);
        check("ord3", out_log[3], 64'h300);

        // Sustained traffic on both requesters; ready must throttle at occupancy 3.
        out_log.delete();
        p0 = 64'h1000;
        p1 = 64'h2000;
        low_seen = 0;
        acc_cnt  = 0;
        for (int c = 0; c < 30; c++) begin
            req_i[0] = mk(p0);
            req_i[1] = mk(p1);
            tick();
            if (!last_ready) low_seen++;
            if (acc_mask[0]) begin p0 += 64'h8; acc_cnt++; end
            if (acc_mask[1]) begin p1 += 64'h8; acc_cnt++; end
        end
        req_i = '0;
        repeat (8) tick();
        check("ready_drop", 64'(low_seen != 0), 64'd1);
        check("no_loss", 64'(out_log.size()), 64'(acc_cnt));
        check("drained", 64'(exp_q.size()), 64'd0);

        // Flush with three entries queued: nothing emitted, then clear sequence.
        req_i[0] = mk(64'h500);
        req_i[1] = mk(64'h600);
        tick();
        req_i[0] = mk(64'h700);
        req_i[1] = mk(64'h800);
        tick();
        req_i = '0;
        check("q3", 64'(exp_q.size()), 64'd3);
        out_log.delete();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        busy_fall("busy_fall");
        check("flush_none", 64'(out_log.size()), 64'd0);

        // Flush re-asserted mid-clear restarts the sequence.
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
`ifdef BHT_SCHED_CLEAR_WALK_EN
        repeat (100) tick();
        check("at_row100", 64'(clr_row_o), 64'd100);
`endif
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        busy_fall("reflush_fall");

        // Debug mode: requests acknowledged and dropped.
        debug_mode_i = 1'b1;
        req_i[0] = mk(64'h900);
        req_i[1] = mk(64'hA00);
        repeat (5) tick();
        req_i = '0;
        debug_mode_i = 1'b0;
        repeat (2) tick();
        check("dbg_ready", 64'(last_ready), 64'd1);

        // Reset during a clear aborts it with no resumed sweep.
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        do_reset();
        repeat (4) tick();
        check("rst_abort", 64'({clr_valid_o, clr_all_o, busy_o}), 64'd0);

        // Traffic still works after reset.
        out_log.delete();
        req_i[0] = mk(64'hB00);
        req_i[1] = mk(64'hC00);
        tick();
        req_i = '0;
        repeat (4) tick();
        check("post_rst0", out_log[0], 64'hB00);
        check("post_rst1", out_log[1], 64'hC00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
